// File: rtl/sd_feeder_pkg.sv
// sd_feeder_pkg: shared sizes, pad default and write-FSM state encoding for the sector feeder
package sd_feeder_pkg;
  localparam int SECTOR_WORDS_DEF = 256;
  localparam int CNT_W = 9;
  localparam logic [15:0] PAD_WORD_DEF = 16'hFFFF;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, STREAM, DONE} wr_state_t;
endpackage

// File: rtl/sd_sector_ram.sv
// sd_sector_ram: 512x16 simple dual-port RAM, two 256-word banks selected by address bit 8
// Ports: i_clk clock; i_we/i_waddr/i_wdata write port; i_re/i_raddr read port; o_q registered read data
module sd_sector_ram (
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [8:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic        i_re,
  input  logic [8:0]  i_raddr,
  output logic [15:0] o_q
);
  logic [15:0] r_mem [0:511];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_q <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sd_sector_feeder.sv
// sd_sector_feeder: packs a 16-bit stream into ping-pong 256-word sectors and feeds the SD write master
// Ports: sys_clk/sys_rst clock and async reset; init_end gates write starts;
//        in_valid/in_data/in_ready input stream; flush pads the partial sector;
//        wr_en/wr_addr/wr_data/wr_busy/wr_req master write port; overflow sticky drop flag;
//        sectors_written completed sector count
module sd_sector_feeder
  import sd_feeder_pkg::*;
#(
  parameter logic [31:0] START_SECTOR = 32'd0,
  parameter logic [15:0] PAD_WORD     = PAD_WORD_DEF,
  parameter int          SECTOR_WORDS = SECTOR_WORDS_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        overflow,
  output logic [31:0] sectors_written
);
  logic [1:0]       r_full;
  logic             r_fill_bank;
  logic [CNT_W-1:0] r_fill_cnt;
  logic             r_pad;
  logic             r_overflow;
  wr_state_t        r_state;
  wr_state_t        w_next;
  logic             r_rd_bank;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_rd_pad;
  logic             r_rd_any;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_sectors;
  logic             w_in_ready;
  logic             w_we;
  logic             w_last;
  logic             w_rd;
  logic             w_done;
  logic [15:0]      w_q;
  assign w_in_ready = !r_full[r_fill_bank] && !r_pad;
  assign w_we       = (in_valid && w_in_ready) || r_pad;
  assign w_last     = w_we && r_fill_cnt == CNT_W'(SECTOR_WORDS - 1);
  assign w_rd       = r_state == STREAM && wr_req;
  assign w_done     = r_state == DONE;
  sd_sector_ram u_ram (
    .i_clk   (sys_clk),
    .i_we    (w_we),
    .i_waddr ({r_fill_bank, r_fill_cnt[7:0]}),
    .i_wdata (r_pad ? PAD_WORD : in_data),
    .i_re    (w_rd && !r_rd_cnt[CNT_W-1]),
    .i_raddr ({r_rd_bank, r_rd_cnt[7:0]}),
    .o_q     (w_q)
  );
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_full      <= 2'b00;
      r_fill_bank <= 1'b0;
      r_fill_cnt  <= '0;
      r_pad       <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (in_valid && !w_in_ready) r_overflow <= 1'b1;
      if (w_we) r_fill_cnt <= w_last ? '0 : r_fill_cnt + CNT_W'(1);
      if (w_last) begin
        r_fill_bank <= ~r_fill_bank;
        r_pad       <= 1'b0;
      end
      // a flush landing on the word that completes the sector has nothing left to pad
      if (flush && !r_pad && r_fill_cnt != '0 && !w_last) r_pad <= 1'b1;
      // release and fill always target different banks, so both updates coexist
      if (w_done) r_full[r_rd_bank] <= 1'b0;
      if (w_last) r_full[r_fill_bank] <= 1'b1;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = init_end && r_full[r_rd_bank] ? START : IDLE;
      START:     w_next = WAIT_BUSY;
      WAIT_BUSY: w_next = wr_busy ? STREAM : WAIT_BUSY;
      STREAM:    w_next = wr_busy ? STREAM : DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_rd_pad  <= 1'b0;
      r_rd_any  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= START_SECTOR;
      r_sectors <= 32'd0;
    end else begin
      r_state <= w_next;
      r_wr_en <= r_state == START;
      // read counter saturates at 256; later beats return the pad word
      if (w_rd) begin
        r_rd_any <= 1'b1;
        r_rd_pad <= r_rd_cnt[CNT_W-1];
        if (!r_rd_cnt[CNT_W-1]) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
      if (w_done) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= ~r_rd_bank;
        r_wr_addr <= r_wr_addr + 32'd1;
        r_sectors <= r_sectors + 32'd1;
      end
    end
  end
  assign in_ready        = w_in_ready;
  assign wr_en           = r_wr_en;
  assign wr_addr         = r_wr_addr;
  assign wr_data         = !r_rd_any ? 16'h0000 : r_rd_pad ? PAD_WORD : w_q;
  assign overflow        = r_overflow;
  assign sectors_written = r_sectors;
endmodule

// File: tb/tb_sd_sector_feeder.sv
// tb_sd_sector_feeder: directed/randomized bench with a queue-based sector model and a write-master responder
module tb_sd_sector_feeder;
  localparam logic [31:0] START = 32'hFFFF_FFFF;
  localparam logic [15:0] PAD = 16'hFFFF;
  logic        sys_clk = 1'b0;
  logic        sys_rst, init_end, in_valid, flush, wr_busy, wr_req;
  logic [15:0] in_data;
  logic        in_ready, wr_en, overflow;
  logic [31:0] wr_addr, sectors_written;
  logic [15:0] wr_data;
  int total = 0;
  int bad = 0;
  int busy_delay = 0;
  int beats = 256;
  int extra_pad = 0;
  bit kill = 1'b0;
  logic req_d = 1'b0;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  logic [15:0] pend[$];
  logic [31:0] got_addr[$];
  int stall_n;
  sd_sector_feeder #(.START_SECTOR(START), .PAD_WORD(PAD), .SECTOR_WORDS(256)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_busy(wr_busy), .wr_req(wr_req), .overflow(overflow),
    .sectors_written(sectors_written)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) req_d <= wr_req;
  always @(negedge sys_clk) if (req_d) got.push_back(wr_data);
  initial begin
    wr_busy = 1'b0;
    wr_req = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (wr_en) begin
        got_addr.push_back(wr_addr);
        @(posedge sys_clk); #1 wr_busy = 1'b1;
        for (int i = 0; i < busy_delay && !kill; i++) begin @(posedge sys_clk); #1; end
        for (int i = 0; i < beats && !kill; i++) begin @(posedge sys_clk); #1 if (!kill) wr_req = 1'b1; end
        @(posedge sys_clk); #1 wr_req = 1'b0;
        @(posedge sys_clk); #1 wr_busy = 1'b0;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic model_word(input logic [15:0] d);
    pend.push_back(d);
    if (pend.size() == 256) begin
      foreach (pend[i]) exp_q.push_back(pend[i]);
      repeat (extra_pad) exp_q.push_back(PAD);
      pend.delete();
    end
  endtask
  task automatic model_flush();
    while (pend.size() != 0) model_word(PAD);
  endtask
  task automatic push(input logic [15:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 5000) begin @(negedge sys_clk); n++; end
    if (n >= 5000) chk("push_timeout", 32'(n), 32'd0);
    stall_n = n;
    model_word(d);
    @(posedge sys_clk);
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_sectors(input int n);
    int c = 0;
    while (sectors_written !== 32'(n) && c < 20000) begin @(negedge sys_clk); c++; end
    chk("wait_sectors", sectors_written, 32'(n));
  endtask
  task automatic check_stream(input string tag);
    int mism = 0;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) mism++;
    chk({tag, "_words"}, 32'(mism), 32'd0);
  endtask
  task automatic check_addrs(input int n);
    int mism = 0;
    chk("addr_count", 32'(got_addr.size()), 32'(n));
    for (int k = 0; k < got_addr.size(); k++) if (got_addr[k] !== START + 32'(k)) mism++;
    chk("addr_seq", 32'(mism), 32'd0);
  endtask
  initial begin
    int lat, first_stall, c;
    sys_rst = 1'b1; init_end = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", wr_addr, START);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sectors", sectors_written, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 512; i++) begin
      push(16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    end
    repeat (20) @(negedge sys_clk);
    chk("gated_no_wr_en", 32'(got_addr.size()), 32'd0);
    chk("both_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    repeat (5) begin in_data = 16'($urandom); @(negedge sys_clk); end
    in_valid = 1'b0;
    chk("overflow_set", 32'(overflow), 32'd1);
    repeat (10) @(negedge sys_clk);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    init_end = 1'b1;
    wait_sectors(2);
    check_stream("gated");
    check_addrs(2);
    chk("wrap_wr_addr", wr_addr, 32'd1);
    for (int i = 0; i < 256; i++) push(16'(i));
    lat = 0;
    while (!wr_en && lat < 20) begin @(negedge sys_clk); lat++; end
    chk("wr_en_latency", 32'(lat), 32'd2);
    @(negedge sys_clk);
    chk("wr_en_pulse", 32'(wr_en), 32'd0);
    wait_sectors(3);
    check_stream("single");
    chk("single_wr_addr", wr_addr, 32'd2);
    busy_delay = 2000;
    first_stall = -1;
    for (int i = 0; i < 768; i++) begin
      push(16'($urandom));
      if (stall_n > 0 && first_stall < 0) first_stall = i;
    end
    busy_delay = 0;
    chk("pingpong_first_stall", 32'(first_stall), 32'd512);
    wait_sectors(6);
    check_stream("pingpong");
    check_addrs(6);
    for (int i = 0; i < 10; i++) push(16'hA000 + 16'(i));
    beats = 258;
    extra_pad = 2;
    model_flush();
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    chk("pad_in_ready", 32'(in_ready), 32'd0);
    wait_sectors(7);
    beats = 256;
    extra_pad = 0;
    check_stream("flush");
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    repeat (50) @(negedge sys_clk);
    chk("empty_flush_no_wr_en", 32'(got_addr.size()), 32'd7);
    chk("empty_flush_ready", 32'(in_ready), 32'd1);
    busy_delay = 300;
    for (int i = 0; i < 512; i++) push(16'($urandom));
    c = 0;
    while (got.size() < exp_q.size() - 512 + 100 && c < 5000) begin @(negedge sys_clk); c++; end
    chk("beat100_reached", 32'(got.size()), 32'(exp_q.size() - 412));
    chk("pre_rst_ready", 32'(in_ready), 32'd0);
    sys_rst = 1'b1;
    kill = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", wr_addr, START);
    chk("mid_rst_sectors", sectors_written, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    repeat (6) @(negedge sys_clk);
    kill = 1'b0;
    busy_delay = 0;
    got.delete(); exp_q.delete(); pend.delete(); got_addr.delete();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < 256; i++) push(16'($urandom));
    wait_sectors(1);
    check_stream("recover");
    check_addrs(1);
    chk("recover_wr_addr", wr_addr, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
